dtree_feeder: RTL and testbench

DTREE_FEEDER -- requirements
Module: dtree_feeder

---
 rtl/dtree_feeder.sv | 150 +++++++++++++++
 tb/tb_dtree_feeder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dtree_feeder.sv
// dtree_feeder
// Collects a frame of NFEAT features from a valid/ready byte stream into a
// registered feature bus driving an external combinational decision tree.
// Once the last feature lands it waits SETTLE cycles, captures the tree's
// class into a registered result, and offers it downstream with a
// valid/ready handshake before taking the next frame.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    feature stream, X0 first
//   in_valid   in_data is valid
//   in_ready   block accepts in_data this cycle (only while collecting)
//   abort      synchronous frame discard, overrides everything else
//   x          registered feature bus, x[i] is feature Xi
//   cls_in     class from the combinational tree
//   cls_out    registered class result
//   cls_valid  cls_out is valid
//   cls_ready  downstream accepts cls_out
//   frame_cnt  completed-frame counter (wraps)
module dtree_feeder #(
  parameter int NFEAT  = 9,
  parameter int W      = 8,
  parameter int SETTLE = 1,
  parameter int CW     = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [W-1:0]              in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      abort,
  output logic [NFEAT-1:0][W-1:0]   x,
  input  logic [CW-1:0]             cls_in,
  output logic [CW-1:0]             cls_out,
  output logic                      cls_valid,
  input  logic                      cls_ready,
  output logic [15:0]               frame_cnt
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_SETTLE  = 2'd1,
    S_OUTPUT  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [3:0]                r_idx;
  logic [3:0]                r_cnt;
  logic [NFEAT-1:0][W-1:0]   r_x;
  logic [CW-1:0]             r_cls;
  logic                      r_cls_valid;
  logic [15:0]               r_frame_cnt;
  logic                      w_in_ready;

  logic w_accept;
  logic w_last;
  logic w_settle_done;
  logic w_handshake;

  // abort masks the accept so a byte in the abort cycle never lands
  assign w_accept      = in_valid && (r_state == S_COLLECT) && !abort;
  assign w_last        = w_accept && (r_idx == 4'(NFEAT - 1));
  assign w_settle_done = (r_state == S_SETTLE) && (r_cnt == 4'd1);
  assign w_handshake   = (r_state == S_OUTPUT) && r_cls_valid && cls_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_COLLECT;
    end else begin
      case (r_state)
        S_COLLECT: w_next = w_last ? S_SETTLE : S_COLLECT;
        S_SETTLE:  w_next = w_settle_done ? S_OUTPUT : S_SETTLE;
        S_OUTPUT:  w_next = w_handshake ? S_COLLECT : S_OUTPUT;
        default:   w_next = S_COLLECT;
      endcase
    end
  end

  // Output decode: in_ready depends on state only
  always_comb begin
    w_in_ready = 1'b0;
    if (r_state == S_COLLECT) begin
      w_in_ready = 1'b1;
    end else begin
      w_in_ready = 1'b0;
    end
  end

  // Datapath: feature capture, settle timer, class result, frame counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= 4'd0;
      r_cnt       <= 4'd0;
      r_x         <= '0;
      r_cls       <= '0;
      r_cls_valid <= 1'b0;
      r_frame_cnt <= 16'd0;
    end else if (abort) begin
      // X registers and cls_out are deliberately left untouched
      r_idx       <= 4'd0;
      r_cnt       <= 4'd0;
      r_cls_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < NFEAT; i++) begin
          if (r_idx == 4'(i)) begin
            r_x[i] <= in_data;
          end
        end
        if (w_last) begin
          r_idx <= 4'd0;
          r_cnt <= 4'(SETTLE);
        end else begin
          r_idx <= r_idx + 4'd1;
        end
      end
      if (r_state == S_SETTLE) begin
        if (w_settle_done) begin
          r_cls       <= cls_in;
          r_cls_valid <= 1'b1;
        end
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_handshake) begin
        r_cls_valid <= 1'b0;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign x         = r_x;
  assign cls_out   = r_cls;
  assign cls_valid = r_cls_valid;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_dtree_feeder.sv
module tb_dtree_feeder;
  localparam int NFEAT  = 9;
  localparam int W      = 8;
  localparam int SETTLE = 1;
  localparam int CW     = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [W-1:0]             in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     abort;
  logic [NFEAT-1:0][W-1:0]  x;
  logic [CW-1:0]            cls_in;
  logic [CW-1:0]            cls_out;
  logic                     cls_valid;
  logic                     cls_ready;
  logic [15:0]              frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  dtree_feeder #(.NFEAT(NFEAT), .W(W), .SETTLE(SETTLE), .CW(CW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort), .x(x), .cls_in(cls_in),
    .cls_out(cls_out), .cls_valid(cls_valid), .cls_ready(cls_ready),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        a;
    logic        r;
    logic [1:0]  c;
    logic        e_rdy;
    logic        e_val;
    logic [1:0]  e_cls;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(logic v, logic [7:0] d, logic a, logic r, logic [1:0] c,
                              logic e_rdy, logic e_val, logic [1:0] e_cls, logic [15:0] e_cnt);
    vec_t t;
    t.v = v; t.d = d; t.a = a; t.r = r; t.c = c;
    t.e_rdy = e_rdy; t.e_val = e_val; t.e_cls = e_cls; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] d, input logic a,
                     input logic r, input logic [1:0] c);
    in_valid  = v;
    in_data   = d;
    abort     = a;
    cls_ready = r;
    cls_in    = c;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic feed(input logic [7:0] base, input logic r, input logic [1:0] c);
    for (int i = 0; i < NFEAT; i++) begin
      drv(1'b1, 8'(base + 8'(i)), 1'b0, r, c);
      tick();
    end
  endtask

  // Behavioural reference: bytes gathered so far, edges left until the
  // class is taken, and whether a result is being offered.
  logic [W-1:0] m_x [NFEAT];
  logic [W-1:0] m_q [$];
  int           m_wait;
  logic         m_hold;
  logic [1:0]   m_cls;
  logic [15:0]  m_cnt;

  task automatic model_step();
    if (abort) begin
      m_q.delete();
      m_wait = 0;
      m_hold = 1'b0;
    end else if (m_hold) begin
      if (cls_ready) begin
        m_hold = 1'b0;
        m_cnt  = m_cnt + 16'd1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_cls  = cls_in;
        m_hold = 1'b1;
      end
    end else if (in_valid) begin
      m_x[m_q.size()] = in_data;
      m_q.push_back(in_data);
      if (m_q.size() == NFEAT) begin
        m_q.delete();
        m_wait = SETTLE;
      end
    end
  endtask

  int seen;
  logic rv;
  logic [1:0] rc;

  initial begin
    rst = 1'b1;
    drv(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_cls_valid", 32'(cls_valid), 32'd0);
    chk("rst_cls_out", 32'(cls_out), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_x", 32'(x == '0), 32'd1);
    rst = 1'b0;

    // Nominal frame, bytes 1..9, class 3, downstream always ready
    for (int i = 0; i < NFEAT; i++)
      tbl[i] = mk(1'b1, 8'(i + 1), 1'b0, 1'b1, 2'd3, (i < NFEAT - 1), 1'b0, 2'd0, 16'd0);
    tbl[9]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 2'd3, 16'd0);
    tbl[10] = mk(1'b0, 8'h00, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 2'd3, 16'd1);
    for (int k = 0; k < 11; k++) begin
      drv(tbl[k].v, tbl[k].d, tbl[k].a, tbl[k].r, tbl[k].c);
      tick();
      chk($sformatf("nom%0d_rdy", k), 32'(in_ready), 32'(tbl[k].e_rdy));
      chk($sformatf("nom%0d_val", k), 32'(cls_valid), 32'(tbl[k].e_val));
      chk($sformatf("nom%0d_cls", k), 32'(cls_out), 32'(tbl[k].e_cls));
      chk($sformatf("nom%0d_cnt", k), 32'(frame_cnt), 32'(tbl[k].e_cnt));
    end
    for (int i = 0; i < NFEAT; i++) chk($sformatf("nom_x%0d", i), 32'(x[i]), 32'(i + 1));

    // Backpressure in OUTPUT with a live byte stream
    feed(8'h20, 1'b0, 2'd1);
    drv(1'b0, 8'h00, 1'b0, 1'b0, 2'd1);
    tick();
    chk("bp_valid_up", 32'(cls_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      drv(1'b1, 8'hAA, 1'b0, 1'b0, 2'd2);
      tick();
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_val", 32'(cls_valid), 32'd1);
      chk("bp_cls", 32'(cls_out), 32'd1);
      chk("bp_cnt", 32'(frame_cnt), 32'd1);
      chk("bp_x0", 32'(x[0]), 32'h20);
    end
    drv(1'b1, 8'hAA, 1'b0, 1'b1, 2'd2);
    tick();
    chk("bp_hs_val", 32'(cls_valid), 32'd0);
    chk("bp_hs_cnt", 32'(frame_cnt), 32'd2);
    chk("bp_hs_rdy", 32'(in_ready), 32'd1);
    drv(1'b0, 8'h00, 1'b0, 1'b1, 2'd0);
    tick();
    chk("bp_once_cnt", 32'(frame_cnt), 32'd2);
    chk("bp_x0_kept", 32'(x[0]), 32'h20);
    chk("bp_x8_kept", 32'(x[8]), 32'h28);

    // Gapped input: valid every other cycle
    seen = 0;
    for (int i = 0; i < 2 * NFEAT; i++) begin
      drv((i % 2) == 0, 8'(8'h10 + 8'(i / 2)), 1'b0, 1'b1, 2'd3);
      tick();
      if (cls_valid) seen++;
    end
    for (int j = 0; j < 4; j++) begin
      drv(1'b0, 8'h00, 1'b0, 1'b1, 2'd3);
      tick();
      if (cls_valid) seen++;
    end
    chk("gap_valid_cycles", 32'(seen), 32'd1);
    chk("gap_cnt", 32'(frame_cnt), 32'd3);
    for (int i = 0; i < NFEAT; i++) chk($sformatf("gap_x%0d", i), 32'(x[i]), 32'(8'h10 + 8'(i)));

    // Abort mid-frame together with a byte
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 8'(8'h30 + 8'(i)), 1'b0, 1'b1, 2'd0);
      tick();
    end
    drv(1'b1, 8'hFF, 1'b1, 1'b1, 2'd0);
    tick();
    chk("ab_x4", 32'(x[4]), 32'h14);
    chk("ab_rdy", 32'(in_ready), 32'd1);
    chk("ab_cnt", 32'(frame_cnt), 32'd3);
    feed(8'h40, 1'b1, 2'd2);
    for (int i = 0; i < NFEAT; i++) chk($sformatf("ab_x%0d", i), 32'(x[i]), 32'(8'h40 + 8'(i)));
    chk("ab_cnt_hold", 32'(frame_cnt), 32'd3);
    drv(1'b0, 8'h00, 1'b0, 1'b1, 2'd2);
    tick();
    chk("ab_val", 32'(cls_valid), 32'd1);
    tick();
    chk("ab_after_cnt", 32'(frame_cnt), 32'd4);

    // Abort coinciding with an OUTPUT handshake
    feed(8'h50, 1'b1, 2'd1);
    drv(1'b0, 8'h00, 1'b0, 1'b1, 2'd1);
    tick();
    chk("abhs_val_up", 32'(cls_valid), 32'd1);
    drv(1'b0, 8'h00, 1'b1, 1'b1, 2'd1);
    tick();
    chk("abhs_val", 32'(cls_valid), 32'd0);
    chk("abhs_cnt", 32'(frame_cnt), 32'd4);
    chk("abhs_rdy", 32'(in_ready), 32'd1);

    // Asynchronous reset while settling
    feed(8'h60, 1'b1, 2'd3);
    rst = 1'b1;
    #1;
    chk("ar_val", 32'(cls_valid), 32'd0);
    chk("ar_x", 32'(x == '0), 32'd1);
    chk("ar_cnt", 32'(frame_cnt), 32'd0);
    chk("ar_rdy", 32'(in_ready), 32'd1);
    drv(1'b0, 8'h00, 1'b0, 1'b1, 2'd3);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drv(1'b1, 8'h77, 1'b0, 1'b1, 2'd3);
    tick();
    chk("ar_first_edge_x0", 32'(x[0]), 32'h77);
    for (int k = 0; k < 3; k++) begin
      drv(1'b0, 8'h00, 1'b0, 1'b1, 2'd3);
      tick();
      chk("ar_no_pulse", 32'(cls_valid), 32'd0);
    end

    // Randomized run against the reference, counter preloaded near wrap
    rst = 1'b1;
    drv(1'b0, 8'h00, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
    force dut.r_frame_cnt = 16'hFFF0;
    @(posedge clk);
    #1;
    release dut.r_frame_cnt;
    @(negedge clk);
    for (int i = 0; i < NFEAT; i++) m_x[i] = '0;
    m_q.delete();
    m_wait = 0;
    m_hold = 1'b0;
    m_cls  = 2'd0;
    m_cnt  = 16'hFFF0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_rdy", 32'(in_ready), 32'(!m_hold && m_wait == 0));
      chk("rnd_val", 32'(cls_valid), 32'(m_hold));
      if (m_hold) chk("rnd_cls", 32'(cls_out), 32'(m_cls));
      chk("rnd_cnt", 32'(frame_cnt), 32'(m_cnt));
      for (int i = 0; i < NFEAT; i++) chk("rnd_x", 32'(x[i]), 32'(m_x[i]));
      rv = ($urandom_range(3) != 0);
      rc = 2'($urandom_range(3));
      drv(rv, 8'($urandom_range(255)), ($urandom_range(63) == 0),
          ($urandom_range(1) == 1), rc);
      model_step();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
